// File: rtl/note_scheduler.sv
// rtl/note_scheduler.sv - beat-driven lane-pattern sequencer with clk-domain beat enables
// Optional feature macro: NOTE_SCHED_LOOP_EN (adds loop input, wraps song instead of ending)
module note_scheduler #(
    parameter int  CLK_HZ   = 100_000_000,
    parameter int  BASE_HZ  = 1,
    parameter int  SONG_LEN = 16,
    parameter int  LANES    = 4,
    localparam int SW       = $clog2(SONG_LEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic [1:0]       tempo,
`ifdef NOTE_SCHED_LOOP_EN
    input  logic             loop,
`endif
    input  logic             wr_en,
    input  logic [SW-1:0]    wr_addr,
    input  logic [LANES-1:0] wr_data,
    output logic [LANES-1:0] note,
    output logic             note_strobe,
    output logic [SW-1:0]    step,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state
);

    localparam int PER0 = CLK_HZ / BASE_HZ;
    localparam int PER1 = CLK_HZ / (BASE_HZ * 2);
    localparam int PER2 = CLK_HZ / (BASE_HZ * 4);
    localparam int PER3 = CLK_HZ / (BASE_HZ * 8);
    localparam int CW   = (PER0 > 2) ? $clog2(PER0) : 1;

    localparam logic [CW-1:0] PM1_0     = CW'(PER0 - 1);
    localparam logic [CW-1:0] PM1_1     = CW'(PER1 - 1);
    localparam logic [CW-1:0] PM1_2     = CW'(PER2 - 1);
    localparam logic [CW-1:0] PM1_3     = CW'(PER3 - 1);
    localparam logic [SW-1:0] LAST_STEP = SW'(SONG_LEN - 1);

    generate
        if (PER3 < 2) begin : g_bad_period
            $error("note_scheduler: fastest beat period must be at least 2 clocks");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [SW-1:0]    step_q;
    logic [LANES-1:0] note_q;
    logic             strobe_q;
    logic             done_q;
    logic [1:0]       tempo_q;
    logic [CW-1:0]    per_m1;
    logic             busy_w;
    logic             loop_w;
    logic [LANES-1:0] pat_q [SONG_LEN];

`ifdef NOTE_SCHED_LOOP_EN
    assign loop_w = loop;
`else
    assign loop_w = 1'b0;
`endif

    assign busy_w = (state_q == S_RUN) || (state_q == S_PAUSE);

    always_comb begin
        per_m1 = PM1_0;
        case (tempo_q)
            2'd1:    per_m1 = PM1_1;
            2'd2:    per_m1 = PM1_2;
            2'd3:    per_m1 = PM1_3;
            default: per_m1 = PM1_0;
        endcase
    end

    // Pattern RAM survives reset; writes are locked out while a song plays.
    always_ff @(posedge clk) begin
        if (wr_en && !busy_w) begin
            pat_q[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            step_q   <= '0;
            note_q   <= '0;
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
            tempo_q  <= 2'd0;
        end else begin
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
            if (stop) begin
                state_q <= S_IDLE;
                cnt_q   <= '0;
                step_q  <= '0;
                note_q  <= '0;
            end else if (start && !busy_w) begin
                state_q  <= S_RUN;
                cnt_q    <= '0;
                step_q   <= '0;
                note_q   <= pat_q[0];
                strobe_q <= 1'b1;
                tempo_q  <= tempo;
            end else if (busy_w) begin
                // The resume edge counts like a running edge, so a beat stretches by exactly the paused cycles.
                if (pause) begin
                    state_q <= S_PAUSE;
                end else begin
                    state_q <= S_RUN;
                    if (cnt_q == per_m1) begin
                        cnt_q <= '0;
                        if (step_q != LAST_STEP) begin
                            step_q   <= step_q + SW'(1);
                            note_q   <= pat_q[step_q + SW'(1)];
                            strobe_q <= 1'b1;
                            tempo_q  <= tempo;
                        end else if (loop_w) begin
                            step_q   <= '0;
                            note_q   <= pat_q[0];
                            strobe_q <= 1'b1;
                            tempo_q  <= tempo;
                        end else begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            note_q  <= '0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
            end
        end
    end

    assign note        = note_q;
    assign note_strobe = strobe_q;
    assign step        = step_q;
    assign busy        = busy_w;
    assign done        = done_q;
    assign state       = state_q;

endmodule

// File: tb/tb_note_scheduler.sv
// tb/tb_note_scheduler.sv - directed self-checking bench for note_scheduler (CLK_HZ=16, SONG_LEN=4)
module tb_note_scheduler;

    logic       clk = 1'b0;
    logic       rst, start, stop, pause;
    logic [1:0] tempo;
`ifdef NOTE_SCHED_LOOP_EN
    logic       loop;
`endif
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [3:0] wr_data;
    logic [3:0] note;
    logic       note_strobe;
    logic [1:0] step;
    logic       busy, done;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_pat [4];

    note_scheduler #(
        .CLK_HZ  (16),
        .BASE_HZ (1),
        .SONG_LEN(4),
        .LANES   (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .pause      (pause),
        .tempo      (tempo),
`ifdef NOTE_SCHED_LOOP_EN
        .loop       (loop),
`endif
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .note       (note),
        .note_strobe(note_strobe),
        .step       (step),
        .busy       (busy),
        .done       (done),
        .state      (state)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [1:0] a, input logic [3:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        logic [10:0] got;
        rst = 1'b1;
        tick(); tick();
        got = {note_strobe, note, step, done, state, busy};
        checks++;
        if (got !== 11'b0) begin
            errors++; $display("FAIL reset_outputs: got %b expected %b", got, 11'b0);
        end
        rst = 1'b0;
        tick();
        got = {note_strobe, note, step, done, state, busy};
        checks++;
        if (got !== 11'b0) begin
            errors++; $display("FAIL idle_after_reset: got %b expected %b", got, 11'b0);
        end
    endtask

    task automatic test_basic_song();
        logic [10:0] got, exp;
        logic [1:0]  es;
        for (int a = 0; a < 4; a++) do_write(2'(a), exp_pat[a]);
        tempo = 2'd0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i <= 64; i++) begin
            es  = (i < 64) ? 2'(i / 16) : 2'd3;
            got = {note_strobe, note, step, done, state, busy};
            exp = {(i < 64) && (i % 16 == 0), (i < 64) ? exp_pat[es] : 4'd0, es,
                   i == 64, (i < 64) ? 2'd1 : 2'd3, i < 64};
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL basic_song cycle %0d: got %b expected %b", i, got, exp);
            end
            if (i < 64) tick();
        end
        tick();
        got = {note_strobe, note, step, done, state, busy};
        exp = {1'b0, 4'd0, 2'd3, 1'b0, 2'd3, 1'b0};
        checks++;
        if (got !== exp) begin
            errors++; $display("FAIL after_done: got %b expected %b", got, exp);
        end
    endtask

    task automatic test_tempo_change();
        logic [10:0] got, exp;
        logic [1:0]  es;
        tempo = 2'd2; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i <= 40; i++) begin
            if (i == 5) tempo = 2'd0;
            es  = (i < 4) ? 2'd0 : (i < 8) ? 2'd1 : (i < 24) ? 2'd2 : 2'd3;
            got = {note_strobe, note, step, done, state, busy};
            exp = {(i == 0) || (i == 4) || (i == 8) || (i == 24),
                   (i < 40) ? exp_pat[es] : 4'd0, es, i == 40,
                   (i < 40) ? 2'd1 : 2'd3, i < 40};
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL tempo_change cycle %0d: got %b expected %b", i, got, exp);
            end
            if (i < 40) tick();
        end
    endtask

    task automatic test_pause();
        logic [10:0] got, exp;
        logic [1:0]  es, est;
        tempo = 2'd2; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i <= 21; i++) begin
            pause = (i >= 1) && (i <= 5);
            es  = (i < 9) ? 2'd0 : (i < 13) ? 2'd1 : (i < 17) ? 2'd2 : 2'd3;
            est = (i == 21) ? 2'd3 : ((i >= 2) && (i <= 6)) ? 2'd2 : 2'd1;
            got = {note_strobe, note, step, done, state, busy};
            exp = {(i == 0) || (i == 9) || (i == 13) || (i == 17),
                   (i < 21) ? exp_pat[es] : 4'd0, es, i == 21, est, i < 21};
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL pause cycle %0d: got %b expected %b", i, got, exp);
            end
            if (i < 21) tick();
        end
        pause = 1'b0;
    endtask

    task automatic test_stop_and_write();
        logic [10:0] got, exp;
        logic [1:0]  es;
        tempo = 2'd2; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i <= 10; i++) begin
            wr_en = (i == 2); wr_addr = 2'd0; wr_data = 4'hF;
            stop  = (i == 9);
            es  = 2'(i / 4);
            got = {note_strobe, note, step, done, state, busy};
            exp = (i < 10) ? {i % 4 == 0, exp_pat[es], es, 1'b0, 2'd1, 1'b1} : 11'b0;
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL stop_mid_song cycle %0d: got %b expected %b", i, got, exp);
            end
            if (i < 10) tick();
        end
        stop = 1'b0; wr_en = 1'b0;
        for (int j = 0; j < 3; j++) begin
            tick();
            checks++;
            if ({done, state, note_strobe} !== 4'b0) begin
                errors++; $display("FAIL no_done_after_stop %0d: got %b expected %b", j, {done, state, note_strobe}, 4'b0);
            end
        end
        tempo = 2'd3; start = 1'b1;
        tick();
        start = 1'b0;
        got = {note_strobe, note, step, done, state, busy};
        exp = {1'b1, 4'd1, 2'd0, 1'b0, 2'd1, 1'b1};
        checks++;
        if (got !== exp) begin
            errors++; $display("FAIL write_ignored_while_busy: got %b expected %b", got, exp);
        end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        got = {note_strobe, note, step, done, state, busy};
        checks++;
        if (got !== 11'b0) begin
            errors++; $display("FAIL reset_mid_song: got %b expected %b", got, 11'b0);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if ({note_strobe, note} !== 5'b1_0001) begin
            errors++; $display("FAIL pattern_kept_over_reset: got %b expected %b", {note_strobe, note}, 5'b1_0001);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic test_start_stop_priority();
        logic [10:0] got, exp;
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        checks++;
        if ({state, busy, note_strobe} !== 4'b0) begin
            errors++; $display("FAIL start_stop_idle: got %b expected %b", {state, busy, note_strobe}, 4'b0);
        end
        tempo = 2'd0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        got = {note_strobe, note, step, done, state, busy};
        exp = {1'b0, 4'd1, 2'd0, 1'b0, 2'd1, 1'b1};
        checks++;
        if (got !== exp) begin
            errors++; $display("FAIL start_in_run_ignored: got %b expected %b", got, exp);
        end
        repeat (12) tick();
        got = {note_strobe, note, step, done, state, busy};
        exp = {1'b1, 4'd2, 2'd1, 1'b0, 2'd1, 1'b1};
        checks++;
        if (got !== exp) begin
            errors++; $display("FAIL beat_timing_after_start_in_run: got %b expected %b", got, exp);
        end
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        got = {note_strobe, note, step, done, state, busy};
        checks++;
        if (got !== 11'b0) begin
            errors++; $display("FAIL start_stop_run: got %b expected %b", got, 11'b0);
        end
    endtask

`ifdef NOTE_SCHED_LOOP_EN
    task automatic test_loop();
        logic [10:0] got, exp;
        logic [1:0]  es;
        loop = 1'b1; tempo = 2'd3; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i <= 16; i++) begin
            if (i == 12) loop = 1'b0;
            es  = (i < 16) ? 2'((i / 2) % 4) : 2'd3;
            got = {note_strobe, note, step, done, state, busy};
            exp = (i < 16) ? {i % 2 == 0, exp_pat[es], es, 1'b0, 2'd1, 1'b1}
                           : {1'b0, 4'd0, 2'd3, 1'b1, 2'd3, 1'b0};
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL loop cycle %0d: got %b expected %b", i, got, exp);
            end
            if (i < 16) tick();
        end
    endtask
`endif

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; tempo = 2'd0;
        wr_en = 1'b0; wr_addr = 2'd0; wr_data = 4'd0;
`ifdef NOTE_SCHED_LOOP_EN
        loop = 1'b0;
`endif
        exp_pat[0] = 4'd1; exp_pat[1] = 4'd2; exp_pat[2] = 4'd4; exp_pat[3] = 4'd8;
        test_reset();
        test_basic_song();
        test_tempo_change();
        test_pause();
        test_stop_and_write();
        test_start_stop_priority();
`ifdef NOTE_SCHED_LOOP_EN
        test_loop();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
